sound_request_scheduler: RTL and testbench

- Arbitrates one-shot sound requests from up to NUM_REQ game-logic sources onto the single song player.
- Latches one pending request per source and grants by fixed priority.
- Drives the player's playSound/sound inputs and tracks playback via the player's busy indication.
- Enforces a silent gap between sounds and a watchdog timeout.

---
 rtl/sound_request_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_sound_request_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_request_scheduler.sv
// Sound request scheduler: latches one-shot requests per source and feeds the single
// song player by fixed priority, with a start-ack window, playback watchdog and silent gap.
module sound_request_scheduler #(
   parameter  int unsigned NUM_REQ        = 4,
   parameter  int unsigned ACK_CYCLES     = 16,
   parameter  int unsigned GAP_CYCLES     = 1_000_000,
   parameter  int unsigned TIMEOUT_CYCLES = 100_000_000,
   localparam int unsigned IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [2*NUM_REQ-1:0] req_sound,
   input  logic                 player_busy,
   output logic                 play_sound,
   output logic [1:0]           sound,
   output logic [IDW-1:0]       grant_id,
   output logic                 active,
   output logic [NUM_REQ-1:0]   dropped,
   output logic                 timeout
);

   // Zero-length windows collapse to a single cycle so every state is always visited.
   localparam int unsigned ACK_EFF  = (ACK_CYCLES == 0) ? 1 : ACK_CYCLES;
   localparam int unsigned GAP_EFF  = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
   localparam int unsigned TO_EFF   = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
   localparam logic [31:0] ACK_LAST = 32'(ACK_EFF - 1);
   localparam logic [31:0] GAP_LAST = 32'(GAP_EFF - 1);
   localparam logic [31:0] TO_LAST  = 32'(TO_EFF - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LAUNCH  = 2'd1,
      ST_PLAYING = 2'd2,
      ST_GAP     = 2'd3
   } state_t;

   state_t               state_r;
   state_t               state_nx_s;
   logic [31:0]          cnt_r;
   logic [31:0]          cnt_nx_s;
   logic [NUM_REQ-1:0]   pend_r;
   logic [1:0]           code_r [NUM_REQ];
   logic [NUM_REQ-1:0]   dropped_r;
   logic                 play_r;
   logic                 play_nx_s;
   logic                 timeout_r;
   logic                 timeout_nx_s;
   logic                 active_r;
   logic                 active_nx_s;
   logic [1:0]           sound_r;
   logic [IDW-1:0]       grant_id_r;
   logic [IDW-1:0]       sel_s;
   logic                 any_pend_s;
   logic                 grant_s;

   // Lowest pending index wins.
   always_comb begin
      sel_s      = '0;
      any_pend_s = |pend_r;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (pend_r[i]) begin
            sel_s = IDW'(i);
         end else begin
            sel_s = sel_s;
         end
      end
   end

   // Next-state, counter and strobe logic; the counter restarts on every state entry.
   always_comb begin
      state_nx_s   = state_r;
      cnt_nx_s     = cnt_r;
      play_nx_s    = 1'b0;
      timeout_nx_s = 1'b0;
      grant_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cnt_nx_s = 32'd0;
            if (any_pend_s) begin
               grant_s    = 1'b1;
               play_nx_s  = 1'b1;
               state_nx_s = ST_LAUNCH;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            if (player_busy) begin
               cnt_nx_s   = 32'd0;
               state_nx_s = ST_PLAYING;
            end else if (cnt_r == ACK_LAST) begin
               cnt_nx_s   = 32'd0;
               state_nx_s = ST_GAP;
            end else begin
               play_nx_s  = 1'b1;
               cnt_nx_s   = cnt_r + 32'd1;
            end
         end
         ST_PLAYING: begin
            if (!player_busy) begin
               cnt_nx_s   = 32'd0;
               state_nx_s = ST_GAP;
            end else if (cnt_r == TO_LAST) begin
               timeout_nx_s = 1'b1;
               cnt_nx_s     = 32'd0;
               state_nx_s   = ST_GAP;
            end else begin
               cnt_nx_s = cnt_r + 32'd1;
            end
         end
         ST_GAP: begin
            if (cnt_r == GAP_LAST) begin
               cnt_nx_s   = 32'd0;
               state_nx_s = ST_IDLE;
            end else begin
               cnt_nx_s = cnt_r + 32'd1;
            end
         end
         default: begin
            cnt_nx_s   = 32'd0;
            state_nx_s = ST_IDLE;
         end
      endcase
      active_nx_s = (state_nx_s == ST_LAUNCH) || (state_nx_s == ST_PLAYING);
   end

   // FSM state, counter and registered player-facing outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 32'd0;
         play_r     <= 1'b0;
         timeout_r  <= 1'b0;
         active_r   <= 1'b0;
         sound_r    <= 2'd0;
         grant_id_r <= '0;
      end else begin
         state_r   <= state_nx_s;
         cnt_r     <= cnt_nx_s;
         play_r    <= play_nx_s;
         timeout_r <= timeout_nx_s;
         active_r  <= active_nx_s;
         if (grant_s) begin
            sound_r    <= code_r[sel_s];
            grant_id_r <= sel_s;
         end else begin
            sound_r    <= sound_r;
            grant_id_r <= grant_id_r;
         end
      end
   end

   // Pending slots: a new request on a slot being granted refills it without a drop.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pend_r    <= '0;
         dropped_r <= '0;
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            code_r[i] <= 2'd0;
         end
      end else begin
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (req[i]) begin
               pend_r[i]    <= 1'b1;
               code_r[i]    <= req_sound[2*i +: 2];
               dropped_r[i] <= pend_r[i] & ~(grant_s && (sel_s == IDW'(i)));
            end else if (grant_s && (sel_s == IDW'(i))) begin
               pend_r[i]    <= 1'b0;
               dropped_r[i] <= 1'b0;
            end else begin
               dropped_r[i] <= 1'b0;
            end
         end
      end
   end

   assign play_sound = play_r;
   assign sound      = sound_r;
   assign grant_id   = grant_id_r;
   assign active     = active_r;
   assign dropped    = dropped_r;
   assign timeout    = timeout_r;

endmodule

// File: tb/tb_sound_request_scheduler.sv
// Directed bench for sound_request_scheduler with a behavioural song-player model
// (busy rises two clocks after play_sound, then holds 20 clocks, never, or forever).
module tb_sound_request_scheduler;

   localparam int M_NORMAL  = 0;
   localparam int M_NEVER   = 1;
   localparam int M_FOREVER = 2;

   logic       clock;
   logic       reset;
   logic [3:0] req;
   logic [7:0] req_sound;
   logic       player_busy;
   logic       play_sound;
   logic [1:0] sound;
   logic [1:0] grant_id;
   logic       active;
   logic [3:0] dropped;
   logic       timeout;

   int pmode;
   int sc;
   int hold;
   int passed;
   int total;
   int to_seen;
   int drop_seen;

   typedef struct {
      logic [3:0] rq;
      logic [7:0] rs;
      logic [1:0] exp_sound;
      logic [1:0] exp_gid;
   } vec_t;

   vec_t vt [5];

   sound_request_scheduler #(
      .NUM_REQ(4), .ACK_CYCLES(4), .GAP_CYCLES(8), .TIMEOUT_CYCLES(50)
   ) dut (
      .clock(clock), .reset(reset), .req(req), .req_sound(req_sound),
      .player_busy(player_busy), .play_sound(play_sound), .sound(sound),
      .grant_id(grant_id), .active(active), .dropped(dropped), .timeout(timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Song player model, updated 1 time unit after each rising edge.
   always begin
      @(posedge clock);
      #1;
      if (!reset || pmode == M_NEVER) begin
         player_busy = 1'b0;
         sc          = 0;
         hold        = 0;
      end else if (player_busy) begin
         if (pmode == M_NORMAL) begin
            hold = hold - 1;
            if (hold == 0) player_busy = 1'b0;
         end
      end else if (play_sound) begin
         sc = sc + 1;
         if (sc == 3) begin
            player_busy = 1'b1;
            hold        = 20;
            sc          = 0;
         end
      end else begin
         sc = 0;
      end
   end

   // Pulse counters sampled away from the active edge.
   always @(negedge clock) begin
      if (timeout === 1'b1) to_seen = to_seen + 1;
      if (dropped[1] === 1'b1) drop_seen = drop_seen + 1;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act === exp) passed = passed + 1;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return play_sound;
         1:       return active;
         2:       return timeout;
         default: return player_busy;
      endcase
   endfunction

   // Ticks until the selected signal equals val; n = -1 if the budget expires.
   task automatic wait_for(input int sel, input logic val, input int maxc, output int n);
      n = -1;
      for (int i = 1; i <= maxc; i++) begin
         tick();
         if (sig(sel) === val) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic do_reset(input int mode);
      pmode     = mode;
      reset     = 1'b0;
      req       = 4'd0;
      req_sound = 8'd0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic pulse(input logic [3:0] rq, input logic [7:0] rs);
      req       = rq;
      req_sound = rs;
      tick();
      req       = 4'd0;
      req_sound = 8'd0;
   endtask

   initial begin
      int n;
      int t0;
      int d0;
      passed    = 0;
      total     = 0;
      to_seen   = 0;
      drop_seen = 0;
      pmode     = M_NEVER;
      reset     = 1'b0;
      req       = 4'd0;
      req_sound = 8'd0;
      player_busy = 1'b0;

      vt[0] = '{4'b0100, 8'b00_11_00_00, 2'd3, 2'd2};
      vt[1] = '{4'b1001, 8'b10_00_00_01, 2'd1, 2'd0};
      vt[2] = '{4'b1110, 8'b01_11_10_00, 2'd2, 2'd1};
      vt[3] = '{4'b1000, 8'b11_00_00_00, 2'd3, 2'd3};
      vt[4] = '{4'b0011, 8'b00_00_11_00, 2'd0, 2'd0};

      #3;
      chk("reset_outputs", {21'd0, play_sound, sound, grant_id, active, dropped, timeout}, 32'd0);
      do_reset(M_NEVER);
      tick();
      chk("post_reset_idle", {21'd0, play_sound, sound, grant_id, active, dropped, timeout}, 32'd0);

      // Table: first grant for several request patterns, then async drop of play_sound.
      for (int v = 0; v < 5; v++) begin
         do_reset(M_NEVER);
         pulse(vt[v].rq, vt[v].rs);
         chk("latch_no_grant_yet", {31'd0, play_sound}, 32'd0);
         tick();
         chk("first_grant", {26'd0, play_sound, sound, grant_id, active},
             {26'd0, 1'b1, vt[v].exp_sound, vt[v].exp_gid, 1'b1});
         #2;
         reset = 1'b0;
         #1;
         chk("async_play_drop", {31'd0, play_sound}, 32'd0);
      end

      // Single request with normal player.
      do_reset(M_NORMAL);
      pulse(4'b0100, 8'b00_11_00_00);
      tick();
      chk("single_grant", {27'd0, play_sound, sound, grant_id}, {27'd0, 1'b1, 2'd3, 2'd2});
      wait_for(0, 1'b0, 10, n);
      chk("single_play_len", n, 32'd3);
      chk("single_busy_at_fall", {31'd0, player_busy}, 32'd1);
      wait_for(1, 1'b0, 40, n);
      chk("single_active_len", n, 32'd20);
      wait_for(0, 1'b1, 15, n);
      chk("single_no_regrant", n, -32'sd1);

      // Priority: source 0 first, source 3 after playing plus the gap.
      do_reset(M_NORMAL);
      pulse(4'b1001, 8'b10_00_00_01);
      tick();
      chk("prio_first", {28'd0, sound, grant_id}, {28'd0, 2'd1, 2'd0});
      wait_for(1, 1'b0, 40, n);
      chk("prio_active_len", n, 32'd23);
      wait_for(0, 1'b1, 20, n);
      chk("prio_gap_len", n, 32'd9);
      chk("prio_second", {28'd0, sound, grant_id}, {28'd0, 2'd2, 2'd3});

      // Overwrite of source 1 while source 0 plays.
      do_reset(M_NORMAL);
      d0 = drop_seen;
      pulse(4'b0001, 8'b00_00_00_11);
      tick();
      repeat (4) tick();
      pulse(4'b0010, 8'b00_00_01_00);
      chk("ovr_first_no_drop", {28'd0, dropped}, 32'd0);
      tick();
      pulse(4'b0010, 8'b00_00_10_00);
      chk("ovr_drop_pulse", {28'd0, dropped}, 32'b0010);
      tick();
      chk("ovr_drop_cleared", {28'd0, dropped}, 32'd0);
      wait_for(0, 1'b1, 40, n);
      chk("ovr_wait", n, 32'd24);
      chk("ovr_grant", {28'd0, sound, grant_id}, {28'd0, 2'd2, 2'd1});
      chk("ovr_drop_count", drop_seen - d0, 32'd1);

      // Ack window expires: player never answers.
      do_reset(M_NEVER);
      t0 = to_seen;
      pulse(4'b1100, 8'b10_01_00_00);
      tick();
      chk("ack_grant", {27'd0, play_sound, sound, grant_id}, {27'd0, 1'b1, 2'd1, 2'd2});
      wait_for(0, 1'b0, 10, n);
      chk("ack_play_len", n, 32'd4);
      chk("ack_in_gap", {31'd0, active}, 32'd0);
      wait_for(0, 1'b1, 20, n);
      chk("ack_gap_len", n, 32'd9);
      chk("ack_next_grant", {28'd0, sound, grant_id}, {28'd0, 2'd2, 2'd3});
      chk("ack_no_timeout", to_seen - t0, 32'd0);

      // Watchdog: player stays busy forever.
      do_reset(M_FOREVER);
      t0 = to_seen;
      pulse(4'b0101, 8'b00_01_00_11);
      tick();
      chk("wd_grant", {28'd0, sound, grant_id}, {28'd0, 2'd3, 2'd0});
      wait_for(2, 1'b1, 80, n);
      chk("wd_timeout_at", n, 32'd53);
      tick();
      chk("wd_pulse_one", {30'd0, timeout, active}, 32'd0);
      wait_for(0, 1'b1, 20, n);
      chk("wd_gap_len", n, 32'd8);
      chk("wd_next_grant", {28'd0, sound, grant_id}, {28'd0, 2'd1, 2'd2});
      chk("wd_pulse_count", to_seen - t0, 32'd1);

      // Async reset mid-playing with source 1 pending.
      do_reset(M_NORMAL);
      pulse(4'b0100, 8'b00_11_00_00);
      tick();
      pulse(4'b0010, 8'b00_00_01_00);
      repeat (3) tick();
      chk("rst_playing", {31'd0, active}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_outputs", {21'd0, play_sound, sound, grant_id, active, dropped, timeout}, 32'd0);
      #2;
      reset = 1'b1;
      wait_for(0, 1'b1, 20, n);
      chk("rst_pend_cleared", n, -32'sd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

endmodule
